// File: rtl/store_unit_pkg.sv
// Shared types for the store path: store kinds, store FSM states and the full-word strobe.
package instr_type;

    typedef enum logic [1:0] {
        sk_sb      = 2'd0,
        sk_sh      = 2'd1,
        sk_sw      = 2'd2,
        sk_invalid = 2'd3
    } store_kind_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } store_state_t;

    localparam logic [3:0] STRB_ALL = 4'b1111;

endpackage

// File: rtl/store_unit_if.sv
// Store request side plus memory write port of the store unit, bundled for one connection.
interface store_unit_if;
    import instr_type::*;

    logic        in_valid;
    logic        in_ready;
    store_kind_t in_kind;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_ack;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        done;
    logic        err_illegal;
    logic        err_misalign;

    // The store unit itself.
    modport slave (
        input  in_valid, in_kind, in_addr, in_data, mem_gnt, mem_ack,
        output in_ready, mem_req, mem_addr, mem_wdata, mem_wstrb,
        output done, err_illegal, err_misalign
    );

    // Whatever issues stores and models memory.
    modport master (
        output in_valid, in_kind, in_addr, in_data, mem_gnt, mem_ack,
        input  in_ready, mem_req, mem_addr, mem_wdata, mem_wstrb,
        input  done, err_illegal, err_misalign
    );

endinterface

// File: rtl/store_unit_align.sv
// Combinational lane steering: byte strobes and replicated write data from kind and addr[1:0].
// misalign flags sh with addr[0] set or sw with any low bit set; sb is never misaligned.
module store_align
    import instr_type::*;
(
    input  store_kind_t kind,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic        misalign
);

    always_comb begin
        wstrb    = 4'b0000;
        wdata    = 32'h0;
        misalign = 1'b0;
        case (kind)
            sk_sb: begin
                wstrb = 4'b0001 << addr_lo;
                wdata = {4{data[7:0]}};
            end
            sk_sh: begin
                // addr[0] is dropped so a misaligned half still lands on a legal lane pair
                wstrb    = 4'b0011 << {addr_lo[1], 1'b0};
                wdata    = {2{data[15:0]}};
                misalign = addr_lo[0];
            end
            sk_sw: begin
                wstrb    = STRB_ALL;
                wdata    = data;
                misalign = |addr_lo;
            end
            default: begin
                wstrb    = 4'b0000;
                wdata    = 32'h0;
                misalign = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/store_unit.sv
// Store unit: accepts one decoded store in S_IDLE, drives a registered req/gnt/ack write, pulses done.
// Config macro STORE_MISALIGN_TRAP_EN: retire misaligned sh/sw with err_misalign instead of writing.
module store_unit
    import instr_type::*;
(
    input  logic        clk,
    input  logic        rst,
    store_unit_if.slave bus
);

    store_state_t state_q, state_d;

    logic        mem_req_q,      mem_req_d;
    logic [31:0] mem_addr_q,     mem_addr_d;
    logic [31:0] mem_wdata_q,    mem_wdata_d;
    logic [3:0]  mem_wstrb_q,    mem_wstrb_d;
    logic        done_q,         done_d;
    logic        err_illegal_q,  err_illegal_d;
    logic        err_misalign_q, err_misalign_d;

    logic        accept;
    logic        acc_illegal;
    logic        acc_trap;
    logic        acc_store;
    logic        trap;
    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata;
    logic        al_misalign;

    store_align u_align (
        .kind     (bus.in_kind),
        .addr_lo  (bus.in_addr[1:0]),
        .data     (bus.in_data),
        .wstrb    (al_wstrb),
        .wdata    (al_wdata),
        .misalign (al_misalign)
    );

`ifdef STORE_MISALIGN_TRAP_EN
    assign trap = al_misalign;
`else
    logic unused_misalign;
    assign unused_misalign = al_misalign;
    assign trap            = 1'b0;
`endif

    assign accept      = bus.in_valid && (state_q == S_IDLE);
    assign acc_illegal = accept && (bus.in_kind == sk_invalid);
    assign acc_trap    = accept && (bus.in_kind != sk_invalid) && trap;
    assign acc_store   = accept && (bus.in_kind != sk_invalid) && !trap;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (acc_store)   state_d = S_REQ;
            S_REQ:  if (bus.mem_gnt) state_d = bus.mem_ack ? S_IDLE : S_WAIT;
            S_WAIT: if (bus.mem_ack) state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase
    end

    // Memory-side outputs are computed one cycle ahead so that every one of them leaves a flop.
    always_comb begin
        mem_req_d      = (state_d == S_REQ);
        done_d         = acc_illegal || acc_trap
                      || ((state_q == S_REQ)  && bus.mem_gnt && bus.mem_ack)
                      || ((state_q == S_WAIT) && bus.mem_ack);
        err_illegal_d  = acc_illegal;
        err_misalign_d = acc_trap;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        mem_wstrb_d    = mem_wstrb_q;
        if (acc_store) begin
            mem_addr_d  = {bus.in_addr[31:2], 2'b00};
            mem_wdata_d = al_wdata;
            mem_wstrb_d = al_wstrb;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req_q      <= 1'b0;
            mem_addr_q     <= 32'h0;
            mem_wdata_q    <= 32'h0;
            mem_wstrb_q    <= 4'b0000;
            done_q         <= 1'b0;
            err_illegal_q  <= 1'b0;
            err_misalign_q <= 1'b0;
        end else begin
            mem_req_q      <= mem_req_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_wstrb_q    <= mem_wstrb_d;
            done_q         <= done_d;
            err_illegal_q  <= err_illegal_d;
            err_misalign_q <= err_misalign_d;
        end
    end

    assign bus.in_ready     = (state_q == S_IDLE);
    assign bus.mem_req      = mem_req_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.mem_wstrb    = mem_wstrb_q;
    assign bus.done         = done_q;
    assign bus.err_illegal  = err_illegal_q;
    assign bus.err_misalign = err_misalign_q;

endmodule
